// File: rtl/rem_pkg.sv
// Shared definitions for the iterative signed-magnitude remainder/quotient unit.
//   state_e    : control FSM states (IDLE -> CALC -> FIX -> IDLE)
//   MODE_*     : encodings of the 'mode' input (truncated / floored)
//   mag_w()    : magnitude width of a signed-magnitude operand of a given width
package rem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic MODE_TRUNC = 1'b0;  // remainder sign follows numerator
  localparam logic MODE_FLOOR = 1'b1;  // remainder sign follows denominator

  // Operands carry their sign in the MSB; the rest is magnitude.
  function automatic int mag_w(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/rem_div_step.sv
// One restoring-division step, purely combinational.
//   rem_i   : partial remainder from the previous step (always < div_i)
//   bit_i   : next dividend bit, MSB first
//   div_i   : divisor magnitude (non-zero while stepping)
//   rem_o   : partial remainder after this step
//   q_bit_o : quotient bit produced by this step
module rem_div_step #(
  parameter int MAG_W = 2
) (
  input  logic [MAG_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [MAG_W-1:0] div_i,
  output logic [MAG_W-1:0] rem_o,
  output logic             q_bit_o
);

  // The shifted remainder is one bit wider than the divisor. Because
  // rem_i < div_i, shifted < 2*div_i: a successful subtraction leaves a
  // value below 2^MAG_W (top bit 0), a failed one wraps to >= 2^MAG_W
  // (top bit 1), so the top bit of the difference is the borrow.
  logic [MAG_W:0] shifted;
  logic [MAG_W:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, div_i};
    q_bit_o = ~trial[MAG_W];
    rem_o   = q_bit_o ? trial[MAG_W-1:0] : shifted[MAG_W-1:0];
  end

endmodule

// File: rtl/rem_seq_div.sv
// Iterative signed-magnitude divider producing remainder and quotient,
// one magnitude bit per clock (restoring), truncated or floored.
//   clk, rst_n            : clock, async active-low reset
//   start / ready         : request accepted on an edge where ready=1
//   mode                  : 0 truncated, 1 floored modulo
//   numerator/denominator : WIDTH-bit signed-magnitude operands
//   valid                 : one-cycle pulse when results update
//   remainder             : OUT_W-bit signed-magnitude, sign at MSB
//   quotient              : WIDTH-bit signed-magnitude
//   divbyzero, zero       : divisor magnitude 0 / remainder magnitude 0
module rem_seq_div
  import rem_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             divbyzero,
  output logic             zero
);

  localparam int MAG_W = mag_w(WIDTH);
  localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] n_mag_q, n_mag_d;
  logic [MAG_W-1:0] d_mag_q, d_mag_d;
  logic [MAG_W-1:0] prem_q, prem_d;
  logic [MAG_W-1:0] quo_q, quo_d;
  logic             n_sign_q, n_sign_d;
  logic             d_sign_q, d_sign_d;
  logic             mode_q, mode_d;
  logic             dbz_q, dbz_d;

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] rem_out_q, rem_out_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic             dbz_out_q, dbz_out_d;
  logic             zero_q, zero_d;

  logic [MAG_W-1:0] step_rem;
  logic             step_q;

  rem_div_step #(.MAG_W(MAG_W)) u_step (
    .rem_i  (prem_q),
    .bit_i  (n_mag_q[cnt_q]),
    .div_i  (d_mag_q),
    .rem_o  (step_rem),
    .q_bit_o(step_q)
  );

  // Sign fix-up of the raw magnitude result.
  logic             adj;
  logic [MAG_W-1:0] r_mag, q_mag;
  logic             r_sign, q_sign;
  logic [OUT_W-1:0] fix_rem;
  logic [WIDTH-1:0] fix_quo;

  always_comb begin
    // Floored mode with differing signs and a non-zero remainder moves the
    // result one divisor step towards -infinity.
    adj    = (mode_q == MODE_FLOOR) && (n_sign_q ^ d_sign_q) && (prem_q != '0);
    r_mag  = adj ? (d_mag_q - prem_q) : prem_q;
    q_mag  = adj ? (quo_q + MAG_W'(1)) : quo_q;
    // Zero magnitudes always come out positive.
    r_sign = (adj ? d_sign_q : n_sign_q) & (r_mag != '0);
    q_sign = (n_sign_q ^ d_sign_q) & (q_mag != '0);
    fix_rem              = '0;
    fix_rem[OUT_W-1]     = r_sign;
    fix_rem[MAG_W-1:0]   = r_mag;
    fix_quo              = {q_sign, q_mag};
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_mag_d   = n_mag_q;
    d_mag_d   = d_mag_q;
    prem_d    = prem_q;
    quo_d     = quo_q;
    n_sign_d  = n_sign_q;
    d_sign_d  = d_sign_q;
    mode_d    = mode_q;
    dbz_d     = dbz_q;
    valid_d   = 1'b0;
    rem_out_d = rem_out_q;
    quo_out_d = quo_out_q;
    dbz_out_d = dbz_out_q;
    zero_d    = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_mag_d  = numerator[MAG_W-1:0];
          n_sign_d = numerator[WIDTH-1];
          d_mag_d  = denominator[MAG_W-1:0];
          d_sign_d = denominator[WIDTH-1];
          mode_d   = mode;
          prem_d   = '0;
          quo_d    = '0;
          cnt_d    = CNT_W'(MAG_W - 1);
          dbz_d    = (denominator[MAG_W-1:0] == '0);
          state_d  = (denominator[MAG_W-1:0] == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        prem_d        = step_rem;
        quo_d[cnt_q]  = step_q;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        valid_d = 1'b1;
        state_d = IDLE;
        if (dbz_q) begin
          rem_out_d = '0;
          quo_out_d = '0;
          dbz_out_d = 1'b1;
          zero_d    = 1'b1;
        end else begin
          rem_out_d = fix_rem;
          quo_out_d = fix_quo;
          dbz_out_d = 1'b0;
          zero_d    = (r_mag == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: the datapath registers are reset along with the control state, so
  // a reset mid-operation leaves no stale operand or partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_mag_q   <= '0;
      d_mag_q   <= '0;
      prem_q    <= '0;
      quo_q     <= '0;
      n_sign_q  <= 1'b0;
      d_sign_q  <= 1'b0;
      mode_q    <= MODE_TRUNC;
      dbz_q     <= 1'b0;
      valid_q   <= 1'b0;
      rem_out_q <= '0;
      quo_out_q <= '0;
      dbz_out_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_mag_q   <= n_mag_d;
      d_mag_q   <= d_mag_d;
      prem_q    <= prem_d;
      quo_q     <= quo_d;
      n_sign_q  <= n_sign_d;
      d_sign_q  <= d_sign_d;
      mode_q    <= mode_d;
      dbz_q     <= dbz_d;
      valid_q   <= valid_d;
      rem_out_q <= rem_out_d;
      quo_out_q <= quo_out_d;
      dbz_out_q <= dbz_out_d;
      zero_q    <= zero_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign valid     = valid_q;
  assign remainder = rem_out_q;
  assign quotient  = quo_out_q;
  assign divbyzero = dbz_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rem_seq_div.sv
// Self-checking bench for rem_seq_div: a WIDTH=3 and a WIDTH=8 instance,
// a table of hand-derived vectors, a back-to-back random stream checked
// against an integer-arithmetic model, busy-start and mid-operation reset.
module tb_rem_seq_div;
  import rem_pkg::*;

  typedef struct {
    logic [9:0] rem;
    logic [7:0] quo;
    logic       dbz;
    logic       zero;
    int         acc;
    int         lat;
  } sb_t;

  typedef struct {
    bit         w8;
    logic [7:0] n;
    logic [7:0] d;
    logic       mode;
    logic [9:0] rem;
    logic [7:0] quo;
    logic       dbz;
    logic       zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       start3, mode3, ready3, valid3, dbz3, zero3;
  logic [2:0] n3, d3, quo3;
  logic [4:0] rem3;
  logic       start8, mode8, ready8, valid8, dbz8, zero8;
  logic [7:0] n8, d8, quo8;
  logic [9:0] rem8;

  rem_seq_div #(.WIDTH(3), .OUT_W(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
    .numerator(n3), .denominator(d3), .ready(ready3), .valid(valid3),
    .remainder(rem3), .quotient(quo3), .divbyzero(dbz3), .zero(zero3)
  );

  rem_seq_div #(.WIDTH(8), .OUT_W(10)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
    .numerator(n8), .denominator(d8), .ready(ready8), .valid(valid8),
    .remainder(rem8), .quotient(quo8), .divbyzero(dbz8), .zero(zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed integer division, then floored correction.
  function automatic sb_t model(input int mw, input int ow, input logic [7:0] n,
                                input logic [7:0] d, input logic m);
    sb_t r;
    int nm, dm, nv, dv, q, rr, rm, qm;
    nm = int'(n) & ((1 << mw) - 1);
    dm = int'(d) & ((1 << mw) - 1);
    r = '{rem: '0, quo: '0, dbz: 1'b1, zero: 1'b1, acc: 0, lat: 0};
    if (dm != 0) begin
      nv = n[mw] ? -nm : nm;
      dv = d[mw] ? -dm : dm;
      q  = nv / dv;
      rr = nv % dv;
      if (m == MODE_FLOOR && rr != 0 && ((rr < 0) != (dv < 0))) begin
        rr = rr + dv;
        q  = q - 1;
      end
      rm = (rr < 0) ? -rr : rr;
      qm = (q < 0) ? -q : q;
      r.rem  = 10'(((rr < 0) ? (1 << (ow - 1)) : 0) | rm);
      r.quo  = 8'(((q < 0) ? (1 << mw) : 0) | qm);
      r.dbz  = 1'b0;
      r.zero = (rm == 0);
    end
    return r;
  endfunction

  // Scoreboards: pushed on accept, popped when valid is due.
  sb_t  sb3[$], sb8[$];
  sb_t  exp_next3, exp_next8, e3, e8;
  logic ev3, ev8;
  logic [31:0] last3 = '0, last8 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb3.delete();
      last3 = '0;
    end else begin
      ev3 = (sb3.size() != 0) && (cyc == sb3[0].acc + sb3[0].lat);
      check("valid3", 32'(valid3), 32'(ev3));
      check("ready3", 32'(ready3), 32'((sb3.size() == 0) || ev3));
      if (ev3) begin
        e3 = sb3.pop_front();
        check("rem3",  32'(rem3),  32'(e3.rem));
        check("quo3",  32'(quo3),  32'(e3.quo));
        check("dbz3",  32'(dbz3),  32'(e3.dbz));
        check("zero3", 32'(zero3), 32'(e3.zero));
        last3 = 32'({rem3, quo3, dbz3, zero3});
      end else begin
        check("hold3", 32'({rem3, quo3, dbz3, zero3}), last3);
      end
      if (start3 && ready3) begin
        e3     = exp_next3;
        e3.acc = cyc + 1;
        e3.lat = e3.dbz ? 1 : 3;
        sb3.push_back(e3);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb8.delete();
      last8 = '0;
    end else begin
      ev8 = (sb8.size() != 0) && (cyc == sb8[0].acc + sb8[0].lat);
      check("valid8", 32'(valid8), 32'(ev8));
      check("ready8", 32'(ready8), 32'((sb8.size() == 0) || ev8));
      if (ev8) begin
        e8 = sb8.pop_front();
        check("rem8",  32'(rem8),  32'(e8.rem));
        check("quo8",  32'(quo8),  32'(e8.quo));
        check("dbz8",  32'(dbz8),  32'(e8.dbz));
        check("zero8", 32'(zero8), 32'(e8.zero));
        last8 = 32'({rem8, quo8, dbz8, zero8});
      end else begin
        check("hold8", 32'({rem8, quo8, dbz8, zero8}), last8);
      end
      if (start8 && ready8) begin
        e8     = exp_next8;
        e8.acc = cyc + 1;
        e8.lat = e8.dbz ? 1 : 8;
        sb8.push_back(e8);
      end
    end
  end

  // Drive one request; returns the edge number on which it was accepted.
  task automatic op(input bit w8, input logic [7:0] n, input logic [7:0] d,
                    input logic m, input sb_t e, input bit hold, output int acc);
    bit got = 1'b0;
    acc = -1;
    if (w8) begin
      n8 = n; d8 = d; mode8 = m; exp_next8 = e; start8 = 1'b1;
    end else begin
      n3 = n[2:0]; d3 = d[2:0]; mode3 = m; exp_next3 = e; start3 = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (w8 ? ready8 : ready3) begin
        got = 1'b1;
        acc = cyc + 1;
      end
    end
    check("accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (w8) start8 = 1'b0;
      else    start3 = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit w8);
    for (int i = 0; i < 60 && (w8 ? sb8.size() : sb3.size()) != 0; i++) @(posedge clk);
    check("drain", 32'(w8 ? sb8.size() : sb3.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    sb_t  e;
    int   acc, prev_acc;
    bit   prev_dbz;
    logic [7:0] rn, rd;
    logic rm;

    vecs[0]  = '{1'b0, 8'h03, 8'h02, MODE_TRUNC, 10'h001, 8'h01, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h07, 8'h02, MODE_TRUNC, 10'h011, 8'h05, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h07, 8'h02, MODE_FLOOR, 10'h001, 8'h06, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h03, 8'h04, MODE_TRUNC, 10'h000, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h03, 8'h06, MODE_FLOOR, 10'h011, 8'h06, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h04, 8'h03, MODE_TRUNC, 10'h000, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h06, 8'h07, MODE_FLOOR, 10'h012, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h02, 8'h07, MODE_FLOOR, 10'h011, 8'h05, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h03, 8'h01, MODE_FLOOR, 10'h000, 8'h03, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h05, 8'h00, MODE_FLOOR, 10'h000, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'h95, 8'h07, MODE_TRUNC, 10'h000, 8'h83, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h7F, 8'h85, MODE_FLOOR, 10'h203, 8'h9A, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'hFF, 8'h7F, MODE_TRUNC, 10'h000, 8'h81, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 8'h64, 8'h03, MODE_TRUNC, 10'h001, 8'h21, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h80, 8'h00, MODE_TRUNC, 10'h000, 8'h00, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 8'hC9, 8'h0A, MODE_FLOOR, 10'h007, 8'h88, 1'b0, 1'b0};

    rst_n = 1'b0;
    start3 = 1'b0; mode3 = 1'b0; n3 = '0; d3 = '0;
    start8 = 1'b0; mode8 = 1'b0; n8 = '0; d8 = '0;
    exp_next3 = '{rem: '0, quo: '0, dbz: 1'b0, zero: 1'b0, acc: 0, lat: 0};
    exp_next8 = exp_next3;
    #1;
    check("rst_ready3", 32'(ready3), 32'd1);
    check("rst_valid3", 32'(valid3), 32'd0);
    check("rst_out3",   32'({rem3, quo3, dbz3, zero3}), 32'd0);
    check("rst_ready8", 32'(ready8), 32'd1);
    check("rst_valid8", 32'(valid8), 32'd0);
    check("rst_out8",   32'({rem8, quo8, dbz8, zero8}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      e = '{rem: vecs[i].rem, quo: vecs[i].quo, dbz: vecs[i].dbz,
            zero: vecs[i].zero, acc: 0, lat: 0};
      op(vecs[i].w8, vecs[i].n, vecs[i].d, vecs[i].mode, e, 1'b0, acc);
      wait_idle(vecs[i].w8);
    end

    // Back-to-back: start held, new operands right after each accept.
    prev_acc = 0;
    prev_dbz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rn = 8'($urandom);
      rd = 8'($urandom);
      rm = 1'($urandom);
      if (k == 3) rd = 8'h80;
      e = model(7, 10, rn, rd, rm);
      op(1'b1, rn, rd, rm, e, k != 7, acc);
      if (k > 0) check("b2b_gap", 32'(acc - prev_acc), prev_dbz ? 32'd2 : 32'd9);
      prev_acc = acc;
      prev_dbz = e.dbz;
    end
    wait_idle(1'b1);

    // Start pulses and operand churn while busy must not disturb the result.
    e = model(7, 10, 8'hB7, 8'h05, MODE_FLOOR);
    op(1'b1, 8'hB7, 8'h05, MODE_FLOOR, e, 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      start8 = ~start8;
      n8 = 8'($urandom);
      d8 = 8'($urandom);
      mode8 = 1'($urandom);
      @(posedge clk);
      #1;
    end
    start8 = 1'b0;
    wait_idle(1'b1);

    // Reset three cycles into CALC: immediate return to reset values.
    e = model(7, 10, 8'h7F, 8'h85, MODE_FLOOR);
    op(1'b1, 8'h7F, 8'h85, MODE_FLOOR, e, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready8", 32'(ready8), 32'd1);
    check("mid_rst_valid8", 32'(valid8), 32'd0);
    check("mid_rst_out8",   32'({rem8, quo8, dbz8, zero8}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    e = model(7, 10, 8'h95, 8'h07, MODE_TRUNC);
    op(1'b1, 8'h95, 8'h07, MODE_TRUNC, e, 1'b0, acc);
    wait_idle(1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rem_seq_div.md
Name: rem_seq_div

Overview:
Parametrised, iterative successor to the 3-bit combinational remainder unit. Takes two WIDTH-bit signed-magnitude operands (MSB = sign) and computes the remainder, plus the quotient, with a start/valid handshake. It uses restoring division at one magnitude bit per clock. It supports truncated (C-style) and floored (modulo) modes and sits in the ALU result path beside the add/mul units.

Parameters:
WIDTH, 3, operand width including sign bit; magnitude width MAG_W = WIDTH-1; legal range 2..32
OUT_W, 5, remainder output width (sign at MSB, magnitude in low MAG_W bits, bits between forced 0); must be >= WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; accepted only on a clock edge where ready=1
mode  input  1  0 = truncated remainder (sign follows numerator), 1 = floored modulo (sign follows denominator)
numerator  input  WIDTH  signed-magnitude dividend, sampled at accept
denominator  input  WIDTH  signed-magnitude divisor, sampled at accept
ready  output  1  high in IDLE; can accept a new operation
valid  output  1  one-cycle pulse; result outputs are new
remainder  output  OUT_W  signed-magnitude remainder
quotient  output  WIDTH  signed-magnitude quotient
divbyzero  output  1  denominator magnitude was 0
zero  output  1  remainder magnitude is 0

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, valid=0, remainder=0, quotient=0, divbyzero=0, zero=0, internal registers cleared.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: if start, latch operand magnitudes, signs and mode.
  - Denominator magnitude == 0: go to FIX, flagging div-by-zero.
  - Otherwise: go to CALC with bit counter = MAG_W-1.
- start while not ready: ignored; no queuing.
- CALC: one restoring step per cycle, MSB first. Shift partial remainder left, bring in next numerator bit, trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; else restore.
  - The partial remainder is MAG_W+1 bits wide to hold the trial subtraction.
  - After MAG_W cycles go to FIX.
- FIX: register outputs, set valid=1 for exactly the following cycle, return to IDLE.
- Truncated mode:
  - remainder magnitude = |n| mod |d|; remainder sign = n sign.
  - quotient magnitude = |n| div |d|; quotient sign = n sign XOR d sign.
- Floored mode, when signs differ and remainder magnitude != 0:
  - remainder magnitude = |d| - r; sign = d sign.
  - quotient magnitude = q + 1; sign = 1.
  - The quotient cannot overflow: |d| >= 2 whenever r != 0.
- Floored mode, otherwise: identical to truncated.
- Zero canonicalisation: any zero magnitude is output with sign 0 (no negative zero), for both remainder and quotient.
- Divide by zero: divbyzero=1, zero=1, remainder=0, quotient=0.
- zero = (remainder magnitude == 0).
- Latency, normal operation: accept edge E0; valid high during the cycle after edge E0+MAG_W+1, i.e. MAG_W+2 cycles after accept.
- Latency, divide by zero: valid high during the cycle after edge E0+1.
- ready is high in the same cycle as valid, so back-to-back operation is permitted: a start during the valid cycle is accepted.
- Outputs hold their last values until the next FIX. valid deasserts after one cycle regardless of start.
- Operand inputs may change freely after the accept edge without affecting the result.
- rst_n asserted mid-operation: abort immediately to reset values; no valid pulse.
- remainder bits [OUT_W-2:MAG_W] are always 0.

Decomposition:
- Shared package rem_pkg:
  - state enum (IDLE, CALC, FIX)
  - mode constants MODE_TRUNC=1'b0, MODE_FLOOR=1'b1
  - helper constant function for MAG_W
- One sub-module, rem_div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- WIDTH=3, OUT_W=5, mode=0: n=3'b011 (+3), d=3'b010 (+2) -> after 4 cycles valid=1, remainder=5'b00001, quotient=3'b001, zero=0, divbyzero=0.
- WIDTH=3, mode=0/1: n=3'b111 (-3), d=3'b010 (+2).
  - mode=0 -> remainder=5'b10001, quotient=3'b101.
  - mode=1 -> remainder=5'b00001, quotient=3'b110.
- WIDTH=3: d=3'b100 (-0), n=3'b011 -> valid 2 cycles after accept, divbyzero=1, zero=1, remainder=0, quotient=0.
- WIDTH=8, OUT_W=10, mode=0: n=8'h95 (-21), d=8'h07 (+7) -> remainder=10'h000 (sign cleared), zero=1, quotient=8'h83 (-3), valid 9 cycles after accept.
- WIDTH=8: start held continuously with new operands each valid cycle -> one result every 9 cycles; start pulses while ready=0 have no effect; outputs unchanged between valids.
- WIDTH=8: rst_n pulled low 3 cycles into CALC -> all outputs 0 and ready=1 immediately; no valid pulse; the next operation computes correctly.
